// File: rtl/auto_baud_detect.sv
// Auto-baud detector: measures a 0x55 sync character on the Rx line and selects
// the nearest supported clocks-per-bit value and rate code for the UART pair.
module auto_baud_detect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Rx,
  input  logic        Start,
  output logic [14:0] BR_Clocks,
  output logic [2:0]  BR_Select,
  output logic        Locked,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam logic [12:0] GUARD     = 13'd4340;
  localparam logic [17:0] TIMEOUT_M = 18'd234383;
  localparam logic [17:0] MIN_M     = 18'd2930;

  typedef enum logic [2:0] {IDLE, HUNT, WAIT_START, MEASURE, DECIDE} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [12:0] guard_q, guard_d;
  logic [17:0] m_q, m_d;
  logic [17:0] s1_q, s1_d;
  logic [2:0]  rise_q, rise_d;
  logic [14:0] br_clocks_q, br_clocks_d;
  logic [2:0]  br_select_q, br_select_d;
  logic        locked_q, locked_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic [2:0] classify(input logic [17:0] m);
    if (m >= 18'd140629)     return 3'd0;
    else if (m >= 18'd78129) return 3'd1;
    else if (m >= 18'd54688) return 3'd2;
    else if (m >= 18'd35154) return 3'd3;
    else if (m >= 18'd19530) return 3'd4;
    else if (m >= 18'd11718) return 3'd5;
    else if (m >= 18'd5859)  return 3'd6;
    else                     return 3'd7;
  endfunction

  function automatic logic [14:0] rate_clocks(input logic [2:0] sel);
    case (sel)
      3'd0:    return 15'd20834;
      3'd1:    return 15'd10417;
      3'd2:    return 15'd6945;
      3'd3:    return 15'd5208;
      3'd4:    return 15'd2604;
      3'd5:    return 15'd1736;
      3'd6:    return 15'd868;
      default: return 15'd434;
    endcase
  endfunction

  logic        rx_rise, rx_fall, fifth_rise, timeout, reject, start_ok;
  logic [21:0] s1_x7, s1_x11, m_wide;
  logic [2:0]  sel_new;

  assign rx_rise    = rx_sync_q & ~rx_prev_q;
  assign rx_fall    = ~rx_sync_q & rx_prev_q;
  assign fifth_rise = rx_rise && (rise_q == 3'd4);
  assign timeout    = (m_q >= TIMEOUT_M);
  assign start_ok   = Start && !done_q;

  // Ratio bounds on the start-bit length via shift-add: 7*S1 = 4+2+1, 11*S1 = 8+2+1.
  assign s1_x7  = {2'b0, s1_q, 2'b0} + {3'b0, s1_q, 1'b0} + {4'b0, s1_q};
  assign s1_x11 = {1'b0, s1_q, 3'b0} + {3'b0, s1_q, 1'b0} + {4'b0, s1_q};
  assign m_wide = {4'b0, m_q};
  assign reject = (m_q < MIN_M) || (m_wide < s1_x7) || (m_wide > s1_x11);
  assign sel_new = classify(m_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      guard_q     <= '0;
      m_q         <= '0;
      s1_q        <= '0;
      rise_q      <= '0;
      br_clocks_q <= 15'd10417;
      br_select_q <= 3'd1;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= Rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      guard_q     <= guard_d;
      m_q         <= m_d;
      s1_q        <= s1_d;
      rise_q      <= rise_d;
      br_clocks_q <= br_clocks_d;
      br_select_q <= br_select_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // NOTE: each combinational process assigns a default to every target first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start_ok) state_d = HUNT;
      HUNT:       if (guard_q == GUARD) state_d = WAIT_START;
      WAIT_START: if (rx_fall) state_d = MEASURE;
      MEASURE: begin
        if (timeout)         state_d = IDLE;
        else if (fifth_rise) state_d = DECIDE;
      end
      DECIDE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    guard_d     = guard_q;
    m_d         = m_q;
    s1_d        = s1_q;
    rise_d      = rise_q;
    br_clocks_d = br_clocks_q;
    br_select_d = br_select_q;
    locked_d    = locked_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          err_d    = 1'b0;
          locked_d = 1'b0;
          busy_d   = 1'b1;
          guard_d  = '0;
        end
      end
      HUNT: guard_d = rx_sync_q ? guard_q + 13'd1 : '0;
      WAIT_START: begin
        if (rx_fall) begin
          m_d    = '0;
          s1_d   = '0;
          rise_d = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          // The edge cycle itself is counted, so M spans exactly falling to 5th rising edge.
          m_d = m_q + 18'd1;
          if (rx_rise) begin
            rise_d = rise_q + 3'd1;
            if (rise_q == 3'd0) s1_d = m_q + 18'd1;
          end
        end
      end
      DECIDE: begin
        busy_d = 1'b0;
        if (reject) begin
          err_d = 1'b1;
        end else begin
          br_select_d = sel_new;
          br_clocks_d = rate_clocks(sel_new);
          locked_d    = 1'b1;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign BR_Clocks = br_clocks_q;
  assign BR_Select = br_select_q;
  assign Locked    = locked_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;

endmodule
